// File: rtl/if_stage.sv
// Instruction-fetch stage: one outstanding SRAM-like fetch, one-entry fetch buffer, redirect squash.
// Optional fetch/cancel performance counters are enabled by defining IF_PERF_CNT_EN.
module if_stage #(
    parameter logic [31:0] RESET_PC = 32'h1c000000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ds_allowin,
    input  logic [33:0] br_bus,
    output logic        fs_to_ds_valid,
    output logic [63:0] fs_to_ds_bus,
    output logic        inst_sram_req,
    output logic        inst_sram_wr,
    output logic [1:0]  inst_sram_size,
    output logic [3:0]  inst_sram_wstrb,
    output logic [31:0] inst_sram_addr,
    output logic [31:0] inst_sram_wdata,
    input  logic        inst_sram_addr_ok,
    input  logic        inst_sram_data_ok,
    input  logic [31:0] inst_sram_rdata
`ifdef IF_PERF_CNT_EN
    ,
    output logic [31:0] fetch_cnt,
    output logic [31:0] cancel_cnt
`endif
);

    localparam logic [0:0] S_REQ  = 1'b0;
    localparam logic [0:0] S_WAIT = 1'b1;

    logic [0:0]  state;
    logic [31:0] pc_r;
    logic [31:0] req_pc;
    logic        discard;
    logic        fs_valid;
    logic [31:0] fs_pc;
    logic [31:0] fs_inst;

    logic        br_cancel;
    logic [31:0] br_target;
    logic        br_taken_unused;
    logic        fetch_go;
    logic        accept;
    logic        resp;
    logic        handoff;

    assign br_cancel       = br_bus[33];
    assign br_taken_unused = br_bus[32];
    assign br_target       = br_bus[31:0];

    // Only request when the buffer will be empty by the time data returns.
    assign fetch_go = (state == S_REQ) && (!fs_valid || ds_allowin) && !reset;
    assign accept   = fetch_go && inst_sram_addr_ok;
    assign resp     = (state == S_WAIT) && inst_sram_data_ok;
    assign handoff  = fs_valid && ds_allowin;

    assign inst_sram_req   = fetch_go;
    assign inst_sram_wr    = 1'b0;
    assign inst_sram_size  = 2'd2;
    assign inst_sram_wstrb = 4'd0;
    assign inst_sram_addr  = pc_r;
    assign inst_sram_wdata = 32'd0;

    assign fs_to_ds_valid = fs_valid && !reset;
    assign fs_to_ds_bus   = reset ? 64'd0 : {fs_inst, fs_pc};

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_REQ;
            pc_r     <= RESET_PC;
            req_pc   <= 32'd0;
            discard  <= 1'b0;
            fs_valid <= 1'b0;
            fs_pc    <= 32'd0;
            fs_inst  <= 32'd0;
        end else if (br_cancel) begin
            fs_valid <= 1'b0;
            pc_r     <= br_target;
            if (accept) begin
                // Old-path request already went out; its response must be thrown away.
                req_pc  <= pc_r;
                state   <= S_WAIT;
                discard <= 1'b1;
            end else if (resp) begin
                state   <= S_REQ;
                discard <= 1'b0;
            end else if (state == S_WAIT) begin
                discard <= 1'b1;
            end
        end else begin
            if (accept) begin
                req_pc <= pc_r;
                pc_r   <= pc_r + 32'd4;
                state  <= S_WAIT;
            end
            if (resp) begin
                state   <= S_REQ;
                discard <= 1'b0;
            end
            if (resp && !discard) begin
                fs_valid <= 1'b1;
                fs_inst  <= inst_sram_rdata;
                fs_pc    <= req_pc;
            end else if (handoff) begin
                fs_valid <= 1'b0;
            end
        end
    end

`ifdef IF_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_cnt  <= 32'd0;
            cancel_cnt <= 32'd0;
        end else begin
            if (handoff && !br_cancel)
                fetch_cnt <= fetch_cnt + 32'd1;
            if (resp && (discard || br_cancel))
                cancel_cnt <= cancel_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: directed vector table plus random traffic against a transaction-level model.
module tb_if_stage;

    localparam logic [31:0] RESET_PC = 32'h1c000000;
    localparam logic [31:0] R = RESET_PC;

    logic        clk = 1'b0;
    logic        reset;
    logic        ds_allowin;
    logic [33:0] br_bus;
    logic        fs_to_ds_valid;
    logic [63:0] fs_to_ds_bus;
    logic        inst_sram_req;
    logic        inst_sram_wr;
    logic [1:0]  inst_sram_size;
    logic [3:0]  inst_sram_wstrb;
    logic [31:0] inst_sram_addr;
    logic [31:0] inst_sram_wdata;
    logic        inst_sram_addr_ok;
    logic        inst_sram_data_ok;
    logic [31:0] inst_sram_rdata;
`ifdef IF_PERF_CNT_EN
    logic [31:0] fetch_cnt;
    logic [31:0] cancel_cnt;
`endif

    if_stage #(.RESET_PC(RESET_PC)) dut (
        .clk(clk),
        .reset(reset),
        .ds_allowin(ds_allowin),
        .br_bus(br_bus),
        .fs_to_ds_valid(fs_to_ds_valid),
        .fs_to_ds_bus(fs_to_ds_bus),
        .inst_sram_req(inst_sram_req),
        .inst_sram_wr(inst_sram_wr),
        .inst_sram_size(inst_sram_size),
        .inst_sram_wstrb(inst_sram_wstrb),
        .inst_sram_addr(inst_sram_addr),
        .inst_sram_wdata(inst_sram_wdata),
        .inst_sram_addr_ok(inst_sram_addr_ok),
        .inst_sram_data_ok(inst_sram_data_ok),
        .inst_sram_rdata(inst_sram_rdata)
`ifdef IF_PERF_CNT_EN
        ,
        .fetch_cnt(fetch_cnt),
        .cancel_cnt(cancel_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst, allow, aok, dok, br;
        logic [31:0] tgt, rdata;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_valid;
        logic [31:0] e_pc, e_inst;
    } vec_t;

    typedef struct {
        logic [31:0] pc;
        bit          live;
    } txn_t;

    vec_t vecs[$];

    // Model: queue of requests in flight, a one-word buffer, and the next fetch address.
    txn_t        outq[$];
    bit          buf_v = 1'b0;
    logic [31:0] buf_pc, buf_inst;
    logic [31:0] m_pc = RESET_PC;
    int unsigned m_fetch = 0;
    int unsigned m_cancel = 0;

    int n_vec = 0;
    int n_err = 0;

    function automatic void add(input logic rst, allow, aok, dok, br,
                                input logic [31:0] tgt, rdata,
                                input logic e_req, input logic [31:0] e_addr,
                                input logic e_valid, input logic [31:0] e_pc, e_inst);
        vec_t v;
        v.rst = rst; v.allow = allow; v.aok = aok; v.dok = dok; v.br = br;
        v.tgt = tgt; v.rdata = rdata;
        v.e_req = e_req; v.e_addr = e_addr; v.e_valid = e_valid;
        v.e_pc = e_pc; v.e_inst = e_inst;
        vecs.push_back(v);
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    function automatic bit model_req();
        return !reset && (outq.size() == 0) && (!buf_v || ds_allowin);
    endfunction

    task automatic model_step();
        bit   acc, resp;
        txn_t t;
        if (reset) begin
            outq.delete();
            buf_v    = 1'b0;
            m_pc     = RESET_PC;
            m_fetch  = 0;
            m_cancel = 0;
        end else begin
            acc  = model_req() && inst_sram_addr_ok;
            resp = inst_sram_data_ok && (outq.size() != 0);
            if (br_bus[33]) begin
                buf_v = 1'b0;
                if (resp) begin
                    void'(outq.pop_front());
                    m_cancel++;
                end
                foreach (outq[i]) outq[i].live = 1'b0;
                if (acc) begin
                    t.pc = m_pc; t.live = 1'b0;
                    outq.push_back(t);
                end
                m_pc = br_bus[31:0];
            end else begin
                if (buf_v && ds_allowin) begin
                    buf_v = 1'b0;
                    m_fetch++;
                end
                if (resp) begin
                    t = outq.pop_front();
                    if (t.live) begin
                        buf_v = 1'b1; buf_pc = t.pc; buf_inst = inst_sram_rdata;
                    end else begin
                        m_cancel++;
                    end
                end
                if (acc) begin
                    t.pc = m_pc; t.live = 1'b1;
                    outq.push_back(t);
                    m_pc = m_pc + 32'd4;
                end
            end
        end
    endtask

    task automatic run(input vec_t v, input bit use_exp, input int idx);
        reset             = v.rst;
        ds_allowin        = v.allow;
        inst_sram_addr_ok = v.aok;
        inst_sram_data_ok = v.dok;
        br_bus            = {v.br, 1'b0, v.tgt};
        inst_sram_rdata   = v.rdata;
        @(negedge clk);
        chk("req", inst_sram_req, model_req());
        if (!reset) chk("addr", inst_sram_addr, m_pc);
        chk("valid", fs_to_ds_valid, !reset && buf_v);
        if (reset) chk("bus_reset", fs_to_ds_bus, 64'd0);
        else if (buf_v) chk("bus", fs_to_ds_bus, {buf_inst, buf_pc});
        chk("const_ports", {inst_sram_wr, inst_sram_size, inst_sram_wstrb, inst_sram_wdata},
            {1'b0, 2'd2, 4'd0, 32'd0});
`ifdef IF_PERF_CNT_EN
        chk("fetch_cnt", fetch_cnt, m_fetch);
        chk("cancel_cnt", cancel_cnt, m_cancel);
`endif
        if (use_exp) begin
            chk($sformatf("t%0d_req", idx), inst_sram_req, v.e_req);
            if (!v.rst) chk($sformatf("t%0d_addr", idx), inst_sram_addr, v.e_addr);
            chk($sformatf("t%0d_valid", idx), fs_to_ds_valid, v.e_valid);
            if (v.e_valid) chk($sformatf("t%0d_bus", idx), fs_to_ds_bus, {v.e_inst, v.e_pc});
        end
        @(posedge clk);
        model_step();
        #1;
    endtask

    initial begin
        vec_t v;
        // reset: rst allow aok dok br tgt rdata | req addr valid pc inst
        add(1,1,1,0,0, 0, 0,              0, R, 0, 0, 0);
        add(1,1,1,0,0, 0, 0,              0, R, 0, 0, 0);
        // straight-line fetch, addr_ok same cycle, data_ok next cycle
        add(0,1,1,0,0, 0, 0,              1, R,        0, 0, 0);
        add(0,1,0,1,0, 0, 32'hA0A0A0A0,   0, R+4,      0, 0, 0);
        add(0,1,1,0,0, 0, 0,              1, R+4,      1, R,   32'hA0A0A0A0);
        add(0,1,0,1,0, 0, 32'hA1A1A1A1,   0, R+8,      0, 0, 0);
        add(0,1,1,0,0, 0, 0,              1, R+8,      1, R+4, 32'hA1A1A1A1);
        add(0,1,0,1,0, 0, 32'hA2A2A2A2,   0, R+12,     0, 0, 0);
        // decode stalls five cycles: no request, buffer stable
        for (int i = 0; i < 5; i++)
            add(0,0,1,0,0, 0, 0,          0, R+12,     1, R+8, 32'hA2A2A2A2);
        add(0,1,1,0,0, 0, 0,              1, R+12,     1, R+8, 32'hA2A2A2A2);
        // redirect while waiting; stale word arrives two cycles later
        add(0,1,0,0,1, R+32'h100, 0,      0, R+16,     0, 0, 0);
        add(0,1,0,0,0, 0, 0,              0, R+32'h100, 0, 0, 0);
        add(0,1,0,1,0, 0, 32'hDEAD0001,   0, R+32'h100, 0, 0, 0);
        add(0,1,1,0,0, 0, 0,              1, R+32'h100, 0, 0, 0);
        add(0,1,0,1,0, 0, 32'hB0B0B0B0,   0, R+32'h104, 0, 0, 0);
        // redirect coincides with addr_ok; buffered word also dropped
        add(0,1,1,0,1, R+32'h200, 0,      1, R+32'h104, 1, R+32'h100, 32'hB0B0B0B0);
        add(0,1,0,1,0, 0, 32'hDEAD0002,   0, R+32'h200, 0, 0, 0);
        add(0,1,1,0,0, 0, 0,              1, R+32'h200, 0, 0, 0);
        // redirect coincides with data_ok
        add(0,1,0,1,1, R+32'h300, 32'hC0C0C0C0, 0, R+32'h204, 0, 0, 0);
        add(0,1,1,0,0, 0, 0,              1, R+32'h300, 0, 0, 0);
        add(0,1,0,1,0, 0, 32'hC1C1C1C1,   0, R+32'h304, 0, 0, 0);
        add(0,1,0,0,0, 0, 0,              1, R+32'h304, 1, R+32'h300, 32'hC1C1C1C1);
        add(0,1,1,0,0, 0, 0,              1, R+32'h304, 0, 0, 0);

        reset = 1'b1; ds_allowin = 1'b0; br_bus = '0;
        inst_sram_addr_ok = 1'b0; inst_sram_data_ok = 1'b0; inst_sram_rdata = '0;
        #1;
        foreach (vecs[i]) run(vecs[i], 1'b1, i);

        // reset while waiting, then a late data_ok must be ignored
        vecs.delete();
        add(1,1,0,0,0, 0, 0,              0, R, 0, 0, 0);
        add(0,1,0,1,0, 0, 32'hBAD0BAD0,   1, R, 0, 0, 0);
        add(0,1,0,0,0, 0, 0,              1, R, 0, 0, 0);
        // redirect in S_REQ without addr_ok: address switches next cycle
        add(0,1,0,0,1, R+32'h400, 0,      1, R, 0, 0, 0);
        add(0,1,1,0,0, 0, 0,              1, R+32'h400, 0, 0, 0);
        add(0,1,0,1,0, 0, 32'hD0D0D0D0,   0, R+32'h404, 0, 0, 0);
        add(0,1,0,0,0, 0, 0,              1, R+32'h404, 1, R+32'h400, 32'hD0D0D0D0);
        foreach (vecs[i]) run(vecs[i], 1'b1, 100 + i);

        for (int i = 0; i < 4000; i++) begin
            v.rst   = ($urandom_range(199) == 0);
            v.allow = ($urandom_range(9) < 6);
            v.aok   = $urandom_range(1);
            v.dok   = (outq.size() != 0) && ($urandom_range(9) < 4);
            v.br    = ($urandom_range(19) == 0);
            v.tgt   = ($urandom_range(4) == 0) ? 32'hFFFFFFF8 : ($urandom & 32'hFFFFFFFC);
            v.rdata = $urandom;
            v.e_req = 0; v.e_addr = 0; v.e_valid = 0; v.e_pc = 0; v.e_inst = 0;
            run(v, 1'b0, i);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
